// File: rtl/pc_trace_monitor.sv
// In-system PC trace unit: logs every PC change with a register snapshot into a
// circular FIFO drained over valid/ready, and flags a halted core or a timeout.
module pc_trace_monitor #(
    parameter int XLEN        = 32,
    parameter int NCH         = 3,
    parameter int DEPTH       = 16,
    parameter int STALL_LIMIT = 8,
    parameter int TIMEOUT     = 10000,
    parameter int WRAP        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_i,
    input  logic [XLEN-1:0]             pc_i,
    input  logic [NCH*XLEN-1:0]         regs_i,
    input  logic                        rd_ready_i,
    output logic                        rd_valid_o,
    output logic [XLEN-1:0]             rd_pc_o,
    output logic [NCH*XLEN-1:0]         rd_regs_o,
    output logic [$clog2(DEPTH):0]      count_o,
    output logic                        overflow_o,
    output logic                        halted_o,
    output logic                        timeout_o,
    output logic [31:0]                 cycles_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = XLEN * (NCH + 1);
    localparam int SW = $clog2(STALL_LIMIT) + 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [SW-1:0] sat_stall(input logic [SW-1:0] v);
        return (v >= SW'(STALL_LIMIT - 1)) ? v : v + SW'(1);
    endfunction

    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            first_armed;
    logic [XLEN-1:0] last_pc;
    logic [SW-1:0]   stall_cnt;

    logic            push, pop, full_after_pop, inc, wr_en, head_adv, ovf_set;
    logic            halt_set, timeout_set;
    logic [CW-1:0]   count_nxt;
    logic [SW-1:0]   stall_nxt;
    logic [31:0]     cycles_nxt;

    // Sample stage: decide push/pop and the next control state
    always_comb begin
        push           = first_armed | (pc_i != last_pc);
        pop            = rd_valid_o & rd_ready_i;
        // pop is applied before push, so a full FIFO being drained accepts the new entry
        full_after_pop = (count == CW'(DEPTH)) & ~pop;
        inc            = push & ~full_after_pop;
        wr_en          = push & (~full_after_pop | (WRAP != 0));
        head_adv       = pop | (push & full_after_pop & (WRAP != 0));
        ovf_set        = push & full_after_pop;
        count_nxt      = count + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, pop};
        stall_nxt      = push ? '0 : sat_stall(stall_cnt);
        halt_set       = (stall_nxt == SW'(STALL_LIMIT - 1));
        cycles_nxt     = sat_inc32(cycles_o);
        timeout_set    = (cycles_nxt == 32'(TIMEOUT)) & ~halted_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            first_armed <= 1'b1;
            last_pc     <= '0;
            stall_cnt   <= '0;
            overflow_o  <= 1'b0;
            halted_o    <= 1'b0;
            timeout_o   <= 1'b0;
            cycles_o    <= '0;
        end else if (clear_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            first_armed <= 1'b1;
            last_pc     <= '0;
            stall_cnt   <= '0;
            overflow_o  <= 1'b0;
            halted_o    <= 1'b0;
            timeout_o   <= 1'b0;
            cycles_o    <= '0;
        end else begin
            if (wr_en)    tail <= tail + AW'(1);
            if (head_adv) head <= head + AW'(1);
            count     <= count_nxt;
            stall_cnt <= stall_nxt;
            cycles_o  <= cycles_nxt;
            if (push) begin
                first_armed <= 1'b0;
                last_pc     <= pc_i;
            end
            if (ovf_set)     overflow_o <= 1'b1;
            if (halt_set)    halted_o   <= 1'b1;
            if (timeout_set) timeout_o  <= 1'b1;
        end
    end

    // Entry storage carries data only; validity is tracked by the pointers and count
    always_ff @(posedge clk) begin
        if (rst && !clear_i && wr_en)
            mem[tail] <= {pc_i, regs_i};
    end

    assign rd_valid_o = (count != '0);
    assign rd_pc_o    = mem[head][EW-1 -: XLEN];
    assign rd_regs_o  = mem[head][NCH*XLEN-1:0];
    assign count_o    = count;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scoreboard bench for pc_trace_monitor: two instances (overwrite and drop modes)
// share the stimulus; expected PCs are queued as they are driven.
module tb_pc_trace_monitor;

    localparam int XLEN  = 32;
    localparam int NCH   = 3;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear_i;
    logic [XLEN-1:0]     pc_i;
    logic [NCH*XLEN-1:0] regs_i;
    logic                rd_ready_i;

    logic                a_valid, b_valid;
    logic [XLEN-1:0]     a_pc, b_pc;
    logic [NCH*XLEN-1:0] a_regs, b_regs;
    logic [CW-1:0]       a_count, b_count;
    logic                a_ovf, b_ovf, a_halt, b_halt, a_tmo, b_tmo;
    logic [31:0]         a_cyc, b_cyc;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        m_first;
    logic [31:0] m_last;

    always #5 clk = ~clk;

    pc_trace_monitor #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .STALL_LIMIT(8),
                       .TIMEOUT(100), .WRAP(1)) dut_a (
        .clk(clk), .rst(rst), .clear_i(clear_i), .pc_i(pc_i), .regs_i(regs_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(a_valid), .rd_pc_o(a_pc),
        .rd_regs_o(a_regs), .count_o(a_count), .overflow_o(a_ovf),
        .halted_o(a_halt), .timeout_o(a_tmo), .cycles_o(a_cyc));

    pc_trace_monitor #(.XLEN(XLEN), .NCH(NCH), .DEPTH(DEPTH), .STALL_LIMIT(8),
                       .TIMEOUT(100), .WRAP(0)) dut_b (
        .clk(clk), .rst(rst), .clear_i(clear_i), .pc_i(pc_i), .regs_i(regs_i),
        .rd_ready_i(rd_ready_i), .rd_valid_o(b_valid), .rd_pc_o(b_pc),
        .rd_regs_o(b_regs), .count_o(b_count), .overflow_o(b_ovf),
        .halted_o(b_halt), .timeout_o(b_tmo), .cycles_o(b_cyc));

    function automatic logic [NCH*XLEN-1:0] regs_of(input logic [31:0] pc);
        return {pc ^ 32'hDEAD_BEEF, pc + 32'd7, ~pc};
    endfunction

    // Drive one sample cycle and update the expected queues; returns #1 after the edge.
    task automatic drive(input logic [31:0] pc, input logic rdy, input logic clr);
        pc_i       = pc;
        regs_i     = regs_of(pc);
        rd_ready_i = rdy;
        clear_i    = clr;
        if (clr) begin
            qa.delete();
            qb.delete();
            m_first = 1'b1;
            m_last  = '0;
        end else begin
            if (rdy && qa.size() > 0) void'(qa.pop_front());
            if (rdy && qb.size() > 0) void'(qb.pop_front());
            if (m_first || pc != m_last) begin
                m_first = 1'b0;
                m_last  = pc;
                if (qa.size() == DEPTH) void'(qa.pop_front());
                qa.push_back(pc);
                if (qb.size() < DEPTH) qb.push_back(pc);
            end
        end
        @(posedge clk);
        #1;
        clear_i = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({a_valid, a_count, a_ovf, a_halt, a_tmo, a_cyc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%0b count=%0d ovf=%0b halt=%0b tmo=%0b cyc=%0d, want all 0",
                     a_valid, a_count, a_ovf, a_halt, a_tmo, a_cyc);
        end
    endtask

    task automatic test_basic_order();
        drive(32'd0, 1'b0, 1'b0);
        drive(32'd4, 1'b0, 1'b0);
        drive(32'd8, 1'b0, 1'b0);
        drive(32'd12, 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(4)) begin
            n_fail++;
            $display("FAIL basic_count: got %0d want 4", a_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (a_valid !== 1'b1 || a_pc !== 32'(i * 4) || a_regs !== regs_of(32'(i * 4)) ||
                qa[0] !== 32'(i * 4)) begin
                n_fail++;
                $display("FAIL basic_pop[%0d]: valid=%0b pc=%0h regs=%0h want pc=%0h regs=%0h",
                         i, a_valid, a_pc, a_regs, i * 4, regs_of(32'(i * 4)));
            end
            drive(m_last, 1'b1, 1'b0);
        end
        n_tests++;
        if (a_valid !== 1'b0 || a_count !== '0) begin
            n_fail++;
            $display("FAIL basic_empty: valid=%0b count=%0d want 0 0", a_valid, a_count);
        end
    endtask

    task automatic test_wrap_and_drop();
        drive(m_last, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) drive(32'(i * 4), 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(16) || a_ovf !== 1'b1 || a_pc !== 32'd16) begin
            n_fail++;
            $display("FAIL wrap_full: count=%0d ovf=%0b head=%0d want 16 1 16", a_count, a_ovf, a_pc);
        end
        n_tests++;
        if (b_count !== CW'(16) || b_ovf !== 1'b1 || b_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL drop_full: count=%0d ovf=%0b head=%0d want 16 1 0", b_count, b_ovf, b_pc);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (a_valid !== 1'b1 || a_pc !== qa[0] || a_regs !== regs_of(qa[0]) ||
                b_valid !== 1'b1 || b_pc !== qb[0] || b_regs !== regs_of(qb[0])) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d]: a_pc=%0d want %0d, b_pc=%0d want %0d",
                         i, a_pc, qa[0], b_pc, qb[0]);
            end
            if (i == 15) begin
                n_tests++;
                if (a_pc !== 32'd76 || b_pc !== 32'd60) begin
                    n_fail++;
                    $display("FAIL wrap_last: a_pc=%0d want 76, b_pc=%0d want 60", a_pc, b_pc);
                end
            end
            drive(m_last, 1'b1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        drive(m_last, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) drive(32'h100 + 32'(i * 4), 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(16) || a_ovf !== 1'b0 || a_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL b2b_fill: count=%0d ovf=%0b head=%0h want 16 0 100", a_count, a_ovf, a_pc);
        end
        drive(32'h200, 1'b1, 1'b0);
        n_tests++;
        if (a_count !== CW'(16) || a_ovf !== 1'b0 || b_count !== CW'(16) || b_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_poppush: a count=%0d ovf=%0b b count=%0d ovf=%0b want 16 0",
                     a_count, a_ovf, b_count, b_ovf);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (a_pc !== qa[0] || b_pc !== qb[0] || (i == 15 && a_pc !== 32'h200)) begin
                n_fail++;
                $display("FAIL b2b_drain[%0d]: a_pc=%0h want %0h, b_pc=%0h want %0h",
                         i, a_pc, qa[0], b_pc, qb[0]);
            end
            drive(m_last, 1'b1, 1'b0);
        end
    endtask

    task automatic test_halt();
        drive(m_last, 1'b0, 1'b1);
        drive(32'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) drive(32'h40, 1'b0, 1'b0);
        n_tests++;
        if (a_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_early: halted=%0b after 7 equal samples want 0", a_halt);
        end
        drive(32'h40, 1'b0, 1'b0);
        n_tests++;
        if (a_halt !== 1'b1 || a_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL halt_set: halted=%0b count=%0d want 1 2", a_halt, a_count);
        end
        for (int i = 0; i < 110; i++) drive(32'h40, 1'b0, 1'b0);
        n_tests++;
        if (a_tmo !== 1'b0 || a_halt !== 1'b1 || a_count !== CW'(2) || a_cyc <= 32'd100) begin
            n_fail++;
            $display("FAIL halt_no_timeout: tmo=%0b halt=%0b count=%0d cyc=%0d want 0 1 2 >100",
                     a_tmo, a_halt, a_count, a_cyc);
        end
    endtask

    task automatic test_timeout_clear();
        logic [31:0] keep;
        drive(m_last, 1'b0, 1'b1);
        n_tests++;
        if (a_cyc !== 32'd0 || a_halt !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_state: cyc=%0d halt=%0b want 0 0", a_cyc, a_halt);
        end
        for (int i = 0; i < 99; i++) drive(32'h1000 + 32'(i * 4), 1'b1, 1'b0);
        n_tests++;
        if (a_cyc !== 32'd99 || a_tmo !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_before: cyc=%0d tmo=%0b want 99 0", a_cyc, a_tmo);
        end
        drive(32'h1000 + 32'd396, 1'b1, 1'b0);
        n_tests++;
        if (a_cyc !== 32'd100 || a_tmo !== 1'b1 || b_tmo !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_at: cyc=%0d a_tmo=%0b b_tmo=%0b want 100 1 1", a_cyc, a_tmo, b_tmo);
        end
        keep = m_last;
        drive(keep, 1'b1, 1'b1);
        n_tests++;
        if ({a_valid, a_count, a_ovf, a_halt, a_tmo, a_cyc} !== '0) begin
            n_fail++;
            $display("FAIL clear_all: valid=%0b count=%0d ovf=%0b halt=%0b tmo=%0b cyc=%0d want 0",
                     a_valid, a_count, a_ovf, a_halt, a_tmo, a_cyc);
        end
        drive(keep, 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(1) || a_pc !== keep || qa[0] !== keep) begin
            n_fail++;
            $display("FAIL clear_first_push: count=%0d pc=%0h want 1 %0h", a_count, a_pc, keep);
        end
    endtask

    task automatic test_async_reset();
        drive(m_last, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(32'h500 + 32'(i * 4), 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(5)) begin
            n_fail++;
            $display("FAIL areset_fill: count=%0d want 5", a_count);
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (a_valid !== 1'b0 || a_count !== '0 || b_valid !== 1'b0 || b_count !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: a valid=%0b count=%0d b valid=%0b count=%0d want 0",
                     a_valid, a_count, b_valid, b_count);
        end
        qa.delete();
        qb.delete();
        m_first = 1'b1;
        m_last  = '0;
        #3 rst = 1'b1;
        drive(32'h77, 1'b0, 1'b0);
        n_tests++;
        if (a_count !== CW'(1) || a_pc !== 32'h77 || a_cyc !== 32'd1) begin
            n_fail++;
            $display("FAIL areset_recover: count=%0d pc=%0h cyc=%0d want 1 77 1", a_count, a_pc, a_cyc);
        end
    endtask

    initial begin
        rst        = 1'b0;
        clear_i    = 1'b0;
        pc_i       = '0;
        regs_i     = regs_of(32'd0);
        rd_ready_i = 1'b0;
        m_first    = 1'b1;
        m_last     = '0;
        #12;
        test_reset();
        rst = 1'b1;
        test_basic_order();
        test_wrap_and_drop();
        test_back_to_back();
        test_halt();
        test_timeout_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
